// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 serial receiver (LSB first) with 2-flop input synchronizer,
//            mid-bit sampling, one-cycle valid / frame_err strobes and a
//            BREAK state that blocks re-triggering on a held-low line.
//            Optional even-parity check when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       RST,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST      = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    ST_PARITY = 3'd5
`endif
  } state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_ok;

`ifdef UART_RX_PARITY_EN
  logic                 par_err;
  assign stop_ok = rx_s & ~par_err;
`else
  assign stop_ok = rx_s;
`endif

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Receive FSM: start-bit qualification, mid-bit sampling, strobe generation.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state <= ST_START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end

        // Re-check the line half a bit in; a high level means it was a glitch.
        ST_START: begin
          if (cnt == CNT_HALF_LAST) begin
            cnt <= '0;
            if (!rx_s) begin
              state <= ST_DATA;
              idx   <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Shift right so the first (LSB) bit ends up at bit 0.
        ST_DATA: begin
          if (cnt == CNT_BIT_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        // Even parity: XOR of data plus parity bit must be zero.
        ST_PARITY: begin
          if (cnt == CNT_BIT_LAST) begin
            cnt     <= '0;
            par_err <= ^{shreg, rx_s};
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        // Leave at mid-stop-bit so a directly following start edge is caught.
        ST_STOP: begin
          if (cnt == CNT_BIT_LAST) begin
            cnt <= '0;
            if (stop_ok) begin
              data  <= 8'(shreg);
              valid <= 1'b1;
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx at CLKS_PER_BIT = 16.
//            Parity vectors are included when UART_RX_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int EXP_OFF = 2 + H + 10 * C;
`else
  localparam int EXP_OFF = 2 + H + 9 * C;
`endif

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t0    = 0;
  int t0_a  = 0;
  int both_cnt = 0;
  int vq[$];
  int eq[$];
  logic [7:0] dq[$];

  uart_rx #(.CLKS_PER_BIT(C), .DATA_BITS(8)) dut (
    .clk       (clk),
    .RST       (RST),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Edge counter; after posedge N it holds N.
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid) begin
      vq.push_back(cyc);
      dq.push_back(data);
    end
    if (frame_err) eq.push_back(cyc);
    if (valid && frame_err) both_cnt <= both_cnt + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Strobe cycle must land within +/-2 cycles of the computed edge.
  task automatic check_time(input string tag, input int qsize, input int got, input int exp);
    logic ok;
    ok = (qsize > 0) && (got >= exp - 2) && (got <= exp + 2);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got cycle %0d (n=%0d) expected %0d +/-2", tag, got, qsize, exp);
    end
  endtask

  // All drive tasks assume they start 1 time unit after a posedge.
  task automatic bit_time(input logic b);
    rx = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input logic par_flip);
    t0 = cyc + 1;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time((^d) ^ par_flip);
`else
    if (par_flip) t0 = t0;
`endif
    bit_time(stop);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", 32'(data), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    RST = 1'b0;
    idle(5);

    // Single good frame 0x48
    send(8'h48, 1'b1, 1'b0);
    t0_a = t0;
    idle(4);
    check("f48_nvalid", 32'(vq.size()), 32'd1);
    if (dq.size() > 0) check("f48_qdata", 32'(dq[0]), 32'h48);
    check_time("f48_time", vq.size(), (vq.size() > 0) ? vq[0] : -1, t0_a + EXP_OFF);
    check("f48_nferr", 32'(eq.size()), 32'd0);
    check("f48_data", 32'(data), 32'h48);
    vq.delete(); dq.delete(); eq.delete();

    // 4-cycle low glitch on idle line
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("glitch_busy_hi", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("glitch_busy_lo", 32'(busy), 32'd0);
    idle(20);
    check("glitch_nvalid", 32'(vq.size()), 32'd0);
    check("glitch_nferr", 32'(eq.size()), 32'd0);

    // Bad stop bit then held-low line
    send(8'h3C, 1'b0, 1'b0);
    t0_a = t0;
    rx = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("ferr_count", 32'(eq.size()), 32'd1);
    check_time("ferr_time", eq.size(), (eq.size() > 0) ? eq[0] : -1, t0_a + EXP_OFF);
    check("ferr_nvalid", 32'(vq.size()), 32'd0);
    check("ferr_data_kept", 32'(data), 32'h48);
    check("ferr_busy_brk", 32'(busy), 32'd1);
    idle(20);
    check("ferr_count2", 32'(eq.size()), 32'd1);
    check("ferr_busy_lo", 32'(busy), 32'd0);
    vq.delete(); dq.delete(); eq.delete();

    // Back-to-back 0x55, 0xAA
    send(8'h55, 1'b1, 1'b0);
    t0_a = t0;
    send(8'hAA, 1'b1, 1'b0);
    idle(20);
    check("b2b_nvalid", 32'(vq.size()), 32'd2);
    if (dq.size() == 2) begin
      check("b2b_d0", 32'(dq[0]), 32'h55);
      check("b2b_d1", 32'(dq[1]), 32'hAA);
      check("b2b_gap", 32'(vq[1] - vq[0]), 32'(10 * C + ((EXP_OFF > 2 + H + 9 * C) ? C : 0)));
    end
    check_time("b2b_time", vq.size(), (vq.size() > 0) ? vq[0] : -1, t0_a + EXP_OFF);
    check("b2b_nferr", 32'(eq.size()), 32'd0);
    check("b2b_data", 32'(data), 32'hAA);
    vq.delete(); dq.delete(); eq.delete();

    // Reset asserted at data bit 4 of a frame
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(1'b0);
    RST = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("mrst_data", 32'(data), 32'h0);
    check("mrst_valid", 32'(valid), 32'h0);
    check("mrst_ferr", 32'(frame_err), 32'h0);
    check("mrst_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
    idle(10);
    send(8'h81, 1'b1, 1'b0);
    t0_a = t0;
    idle(20);
    check("mrst_nvalid", 32'(vq.size()), 32'd1);
    if (dq.size() > 0) check("mrst_qdata", 32'(dq[0]), 32'h81);
    check_time("mrst_time", vq.size(), (vq.size() > 0) ? vq[0] : -1, t0_a + EXP_OFF);
    check("mrst_nferr", 32'(eq.size()), 32'd0);
    vq.delete(); dq.delete(); eq.delete();

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: correct even parity bit is 1
    send(8'h07, 1'b1, 1'b1);
    t0_a = t0;
    idle(20);
    check("par_bad_nferr", 32'(eq.size()), 32'd1);
    check("par_bad_nvalid", 32'(vq.size()), 32'd0);
    check_time("par_bad_time", eq.size(), (eq.size() > 0) ? eq[0] : -1, t0_a + EXP_OFF);
    vq.delete(); dq.delete(); eq.delete();
    send(8'h07, 1'b1, 1'b0);
    idle(20);
    check("par_ok_nvalid", 32'(vq.size()), 32'd1);
    check("par_ok_nferr", 32'(eq.size()), 32'd0);
    check("par_ok_data", 32'(data), 32'h07);
`endif

    check("never_both", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
